// File: rtl/wb_tgen_pkg.sv
// ============================================================================
// Package  : wb_tgen_pkg
// Brief    : Shared types and Wishbone cycle-type constants for the
//            wb_traffic_gen pattern master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_tgen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Cycle type for a given beat position inside a burst of blen beats.
    function automatic logic [2:0] cti_for(input int unsigned beat, input int unsigned blen);
        if (blen <= 1)
            return CTI_CLASSIC;
        if (beat == blen - 1)
            return CTI_EOB;
        return CTI_INCR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_tgen_beat_ctr.sv
// ============================================================================
// Module   : wb_tgen_beat_ctr
// Brief    : Beat-within-burst and word-index counters with last-beat and
//            last-word flags. The word index returns to zero after the last
//            word so the read phase starts again at the base address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_tgen_beat_ctr #(
    parameter int AW        = 32,
    parameter int NWORDS    = 8,
    parameter int BURST_LEN = 4,
    parameter int BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          beat_done,
    output logic [BW-1:0] beat,
    output logic [AW-1:0] word,
    output logic          last_beat,
    output logic          last_word
);

    assign last_beat = (beat == BW'(BURST_LEN - 1));
    assign last_word = (word == AW'(NWORDS - 1));

    // Advance both counters on every completed beat, wrapping at burst / pass end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat <= '0;
            word <= '0;
        end else if (clear) begin
            beat <= '0;
            word <= '0;
        end else if (beat_done) begin
            beat <= last_beat ? '0 : beat + BW'(1);
            word <= last_word ? '0 : word + AW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_traffic_gen.sv
// ============================================================================
// Module   : wb_traffic_gen
// Brief    : Wishbone B3 bus-functional master. On start it writes NWORDS
//            words of DATA_SEED+i from BASE_ADR upward in bursts of
//            BURST_LEN beats, reads them back, compares, and reports
//            done / pass / err_cnt.
//            Optional stall watchdog: define WB_TRAFFIC_GEN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_traffic_gen
    import wb_tgen_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter logic [AW-1:0] BASE_ADR  = AW'(32'h1000),
    parameter int            NWORDS    = 8,
    parameter int            BURST_LEN = 4,
    parameter logic [DW-1:0] DATA_SEED = DW'(32'h12345678),
    parameter int            TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [DW-1:0]   dat_i,
    output logic [AW-1:0]   adr_o,
    output logic [1:0]      bte_o,
    output logic [2:0]      cti_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [DW/8-1:0] sel_o,
    output logic [DW-1:0]   dat_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_cnt
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t          state;
    logic            rd_phase;
    logic [BW-1:0]   beat;
    logic [AW-1:0]   word;
    logic            last_beat;
    logic            last_word;
    logic            beat_done;
    logic            err_inc;
    logic [15:0]     err_nxt;
    logic            timeout_hit;

    function automatic logic [AW-1:0] adr_of(input logic [AW-1:0] idx);
        return BASE_ADR + (idx << 2);
    endfunction

    function automatic logic [DW-1:0] dat_of(input logic [AW-1:0] idx);
        return DATA_SEED + DW'(idx);
    endfunction

    // err_i (with or without ack) terminates the beat just like ack_i.
    assign beat_done = ((state == WR) || (state == RD)) && stb_o && (ack_i || err_i);
    assign err_inc   = timeout_hit ||
                       (beat_done && (err_i || ((state == RD) && (dat_i != dat_of(word)))));
    assign err_nxt   = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;

    wb_tgen_beat_ctr #(
        .AW        (AW),
        .NWORDS    (NWORDS),
        .BURST_LEN (BURST_LEN),
        .BW        (BW)
    ) u_beat_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     ((state == IDLE) && start),
        .beat_done (beat_done),
        .beat      (beat),
        .word      (word),
        .last_beat (last_beat),
        .last_word (last_word)
    );

`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stall_cnt;

    // Count consecutive cycles the strobe waits without a response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (!stb_o || ack_i || err_i)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + TW'(1);
    end

    assign timeout_hit = stb_o && !(ack_i || err_i) && (stall_cnt == TW'(TIMEOUT - 1));
`else
    // Watchdog compiled out: a stalled beat waits for ever.
    assign timeout_hit = 1'b0 && (TIMEOUT != 0);
`endif

    // Main sequencer: IDLE -> write bursts -> read bursts -> FIN, GAP between bursts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_phase <= 1'b0;
            adr_o    <= '0;
            dat_o    <= '0;
            cti_o    <= CTI_CLASSIC;
            bte_o    <= BTE_LINEAR;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            sel_o    <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            done  <= 1'b0;
            bte_o <= BTE_LINEAR;
            sel_o <= '1;
            if (err_inc)
                err_cnt <= err_nxt;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WR;
                        rd_phase <= 1'b0;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        we_o     <= 1'b1;
                        adr_o    <= BASE_ADR;
                        dat_o    <= DATA_SEED;
                        cti_o    <= cti_for(0, BURST_LEN);
                    end
                end

                WR, RD: begin
                    if (timeout_hit) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= FIN;
                    end else if (beat_done) begin
                        if (last_beat) begin
                            cyc_o <= 1'b0;
                            stb_o <= 1'b0;
                            if (last_word && (state == RD)) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                // Include an error counted on this very beat.
                                pass  <= (err_cnt == 16'd0) && !err_inc;
                                state <= FIN;
                            end else begin
                                if (last_word)
                                    rd_phase <= 1'b1;
                                state <= GAP;
                            end
                        end else begin
                            adr_o <= adr_of(word + AW'(1));
                            if (state == WR)
                                dat_o <= dat_of(word + AW'(1));
                            cti_o <= cti_for(32'(beat) + 32'd1, BURST_LEN);
                        end
                    end
                end

                GAP: begin
                    cyc_o <= 1'b1;
                    stb_o <= 1'b1;
                    adr_o <= adr_of(word);
                    cti_o <= cti_for(0, BURST_LEN);
                    if (rd_phase) begin
                        we_o  <= 1'b0;
                        dat_o <= '0;
                        state <= RD;
                    end else begin
                        we_o  <= 1'b1;
                        dat_o <= dat_of(word);
                        state <= WR;
                    end
                end

                FIN: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_traffic_gen.sv
// ============================================================================
// Module   : tb_wb_traffic_gen
// Brief    : Self-checking bench for wb_traffic_gen: a burst instance driven
//            by a table of slave behaviours, plus a classic-cycle instance
//            checked cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_traffic_gen;

    localparam int          NW   = 8;
    localparam int          BL   = 4;
    localparam logic [31:0] SEED = 32'h12345678;
    localparam logic [31:0] BASE = 32'h1000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- burst instance ----------------
    logic        start = 1'b0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] adr_o, dat_o;
    logic [1:0]  bte_o;
    logic [2:0]  cti_o;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic        busy, done, pass;
    logic [15:0] err_cnt;

    wb_traffic_gen #(
        .AW(32), .DW(32), .BASE_ADR(BASE), .NWORDS(NW), .BURST_LEN(BL),
        .DATA_SEED(SEED), .TIMEOUT(255)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ack_i(ack_i), .err_i(err_i),
        .dat_i(dat_i), .adr_o(adr_o), .bte_o(bte_o), .cti_o(cti_o), .cyc_o(cyc_o),
        .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .dat_o(dat_o), .busy(busy),
        .done(done), .pass(pass), .err_cnt(err_cnt)
    );

    // ---------------- classic instance (BURST_LEN=1, NWORDS=2) ----------------
    logic        start1 = 1'b0;
    logic        ack1;
    logic [31:0] dat1i;
    logic [31:0] adr1, dat1o;
    logic [1:0]  bte1;
    logic [2:0]  cti1;
    logic        cyc1, stb1, we1;
    logic [3:0]  sel1;
    logic        busy1, done1, pass1;
    logic [15:0] ec1;

    // Zero-wait slave returning the correct pattern for the addressed word.
    assign ack1  = stb1;
    assign dat1i = SEED + ((adr1 - BASE) >> 2);

    wb_traffic_gen #(
        .AW(32), .DW(32), .BASE_ADR(BASE), .NWORDS(2), .BURST_LEN(1),
        .DATA_SEED(SEED), .TIMEOUT(255)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .ack_i(ack1), .err_i(1'b0),
        .dat_i(dat1i), .adr_o(adr1), .bte_o(bte1), .cti_o(cti1), .cyc_o(cyc1),
        .stb_o(stb1), .we_o(we1), .sel_o(sel1), .dat_o(dat1o), .busy(busy1),
        .done(done1), .pass(pass1), .err_cnt(ec1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected bus contents for global beat n (writes 0..NW-1, then reads).
    function automatic void exp_beat(input int n, output logic [31:0] a, output logic [31:0] w,
                                     output logic [31:0] d, output logic [31:0] c);
        int i;
        i = n % NW;
        a = BASE + 32'(4 * i);
        w = (n < NW) ? 32'd1 : 32'd0;
        d = (n < NW) ? SEED + 32'(i) : 32'd0;
        c = ((i % BL) == BL - 1) ? 32'd7 : 32'd2;
    endfunction

    typedef struct {
        int waits;       // wait states before each response
        int err_beat;    // global beat answered with err_i (-1 none)
        bit both;        // assert ack_i together with err_i
        int bad_beat;    // global read beat returning 0 (-1 none)
        bit restart;     // pulse start mid-run (must be ignored)
        int exp_err;
        bit exp_pass;
        int exp_cycles;  // edges from start edge to done
    } scen_t;

    scen_t tab [6];
    scen_t cur;
    bit    run_en = 1'b0;
    int    beat_n, wcnt, gap_len, bursts;
    bit    prev_cyc;
    logic [31:0] ea, ew, ed, ec;

    // Slave model: answers at the falling edge, checks bus contents every strobe cycle.
    always @(negedge clk) begin
        if (!run_en) begin
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = 32'h0;
            wcnt  = 0;
        end else begin
            if (ack_i || err_i)
                beat_n++;
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = 32'h0;
            if (cyc_o && !prev_cyc)
                bursts++;
            prev_cyc = cyc_o;
            if (busy && !cyc_o)
                gap_len++;
            else if (cyc_o && gap_len != 0) begin
                chk("gap_len", gap_len, 1);
                gap_len = 0;
            end
            if (cyc_o && stb_o) begin
                exp_beat(beat_n, ea, ew, ed, ec);
                chk("adr", adr_o, ea);
                chk("we", {31'd0, we_o}, ew);
                chk("wdat", dat_o, ed);
                chk("cti", {29'd0, cti_o}, ec);
                chk("sel", {28'd0, sel_o}, 32'hF);
                if (wcnt == cur.waits) begin
                    wcnt = 0;
                    if (beat_n == cur.err_beat) begin
                        err_i = 1'b1;
                        ack_i = cur.both;
                    end else begin
                        ack_i = 1'b1;
                    end
                    if (beat_n >= NW)
                        dat_i = (beat_n == cur.bad_beat) ? 32'h0 : SEED + 32'(beat_n - NW);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic begin_scen(input int k);
        cur      = tab[k];
        beat_n   = 0;
        wcnt     = 0;
        gap_len  = 0;
        bursts   = 0;
        prev_cyc = 1'b0;
        run_en   = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("err_cleared", {16'd0, err_cnt}, 0);
    endtask

    task automatic run_scen(input int k);
        int n;
        bit got;
        begin_scen(k);
        n   = 0;
        got = 1'b0;
        while (n < 400 && !got) begin
            @(posedge clk); #1;
            n++;
            start = (cur.restart && n == 10);
            if (done)
                got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, got}, 1);
        chk("cycles", n, cur.exp_cycles);
        chk("err_cnt", {16'd0, err_cnt}, cur.exp_err);
        chk("pass", {31'd0, pass}, {31'd0, cur.exp_pass});
        chk("busy_fin", {31'd0, busy}, 0);
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, done}, 0);
        chk("pass_held", {31'd0, pass}, {31'd0, cur.exp_pass});
        chk("beats", beat_n, 2 * NW);
        chk("bursts", bursts, 2 * NW / BL);
        chk("cyc_idle", {31'd0, cyc_o}, 0);
        run_en = 1'b0;
    endtask

    typedef struct {
        logic        cyc;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        done;
    } cvec_t;

    cvec_t cv [8];

    initial begin
        //            waits err  both bad rst err pass cycles
        tab[0] = '{0, -1, 1'b0, -1, 1'b0, 0, 1'b1, 19};
        tab[1] = '{3, -1, 1'b0, -1, 1'b1, 0, 1'b1, 67};
        tab[2] = '{0, -1, 1'b0, 13, 1'b0, 1, 1'b0, 19};
        tab[3] = '{0,  2, 1'b0, -1, 1'b0, 1, 1'b0, 19};
        tab[4] = '{1, 15, 1'b1, -1, 1'b0, 1, 1'b0, 35};
        tab[5] = '{0,  8, 1'b0, 15, 1'b0, 2, 1'b0, 19};

        cv[0] = '{1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b0};
        cv[1] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0};
        cv[2] = '{1'b1, 1'b1, 32'h1004, 32'h12345679, 1'b0};
        cv[3] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0};
        cv[4] = '{1'b1, 1'b0, 32'h1000, 32'h0,        1'b0};
        cv[5] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0};
        cv[6] = '{1'b1, 1'b0, 32'h1004, 32'h0,        1'b0};
        cv[7] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_adr", adr_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_cti", {29'd0, cti_o}, 0);
        chk("rst_bte", {30'd0, bte_o}, 0);
        chk("rst_cyc_stb_we", {29'd0, cyc_o, stb_o, we_o}, 0);
        chk("rst_sel", {28'd0, sel_o}, 32'hF);
        chk("rst_flags", {29'd0, busy, done, pass}, 0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 0);
        reset_n = 1'b1;

        // Classic single cycles, one GAP between every beat
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            chk("c_cyc", {31'd0, cyc1}, {31'd0, cv[j].cyc});
            chk("c_done", {31'd0, done1}, {31'd0, cv[j].done});
            chk("c_cti", {29'd0, cti1}, 0);
            if (cv[j].cyc) begin
                chk("c_we", {31'd0, we1}, {31'd0, cv[j].we});
                chk("c_adr", adr1, cv[j].adr);
                chk("c_wdat", dat1o, cv[j].wdat);
            end
        end
        chk("c_pass", {31'd0, pass1}, 1);
        chk("c_err_cnt", {16'd0, ec1}, 0);
        chk("c_busy", {31'd0, busy1}, 0);

        // Burst scenarios from the table
        for (int k = 0; k < 6; k++)
            run_scen(k);

        // Reset asserted mid-burst: bus released at once, no resumption
        begin_scen(1);
        repeat (6) @(posedge clk);
        chk("pre_rst_cyc", {31'd0, cyc_o}, 1);
        run_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_cyc_stb", {30'd0, cyc_o, stb_o}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_adr", adr_o, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", {30'd0, cyc_o, busy}, 0);

        // Fresh pass after the abort
        run_scen(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
